// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the tagged memory bus arbiter
//
// Purpose: the arbiter FSM state type, the request bundle and the bus constants
// used by mem_arbiter and mem_rr_pick.
// Ports: none (package).

package mem_bus_pkg;

  localparam int MEM_AW     = 20;  // memory word-address width (1M words)
  localparam int RD_LAT_MAX = 7;   // largest supported read latency
  localparam int LAT_W      = 3;   // counter width able to hold RD_LAT_MAX

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD,
    RWAIT,
    WR,
    DONE,
    HOLD
  } arb_state_t;

  // One requester's transaction; addr is already zero-extended to the bus width.
  typedef struct packed {
    logic [63:0] addr;
    logic        wr;
    logic        atomic;
    logic [63:0] wdata;
    logic [7:0]  wtag;
  } mem_req_t;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - two-way round-robin pick
//
// Purpose: choose one of two requesters; on a tie the one not granted last wins.
// Ports:
//   req0, req1 : request lines
//   last       : index of the requester granted most recently
//   grant      : chosen index (meaningful when valid)
//   valid      : at least one request present

module mem_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;
  // req1 wins when alone, or on a tie when requester 0 was granted last.
  assign grant = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter and sequencer for the tagged memory port
//
// Purpose: arbitrates CPU (0) and I/O-DMA (1) requests onto the single memory bus,
// runs address/data phases, returns read data and supports locked read-modify-write.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   mN_req/addr/wr/atomic/wdata/wtag : requester N transaction, held until mN_ack
//   mN_ack, mN_rdata, mN_rtag      : completion pulse and read data/tag for requester N
//   o_ad, o_tag, o_astb, o_atomic, o_rd, o_wr : memory bus outputs
//   i_data, i_tag                  : memory read data/tag
//   busy, owner                    : transaction/lock in progress, granted requester

module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW     = MEM_AW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wr,
  input  logic          m0_atomic,
  input  logic [63:0]   m0_wdata,
  input  logic [7:0]    m0_wtag,
  output logic          m0_ack,
  output logic [63:0]   m0_rdata,
  output logic [7:0]    m0_rtag,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wr,
  input  logic          m1_atomic,
  input  logic [63:0]   m1_wdata,
  input  logic [7:0]    m1_wtag,
  output logic          m1_ack,
  output logic [63:0]   m1_rdata,
  output logic [7:0]    m1_rtag,
  output logic [63:0]   o_ad,
  output logic [7:0]    o_tag,
  output logic          o_astb,
  output logic          o_atomic,
  output logic          o_rd,
  output logic          o_wr,
  input  logic [63:0]   i_data,
  input  logic [7:0]    i_tag,
  output logic          busy,
  output logic          owner
);

  localparam logic [LAT_W-1:0] LAT = LAT_W'(RD_LAT);

  arb_state_t       state;
  logic             last;      // most recently granted requester
  logic             lock;      // current sequence is a locked read awaiting its follow-up
  logic [LAT_W-1:0] cnt;
  logic             grant;
  logic             gvalid;
  logic             sel_idx;
  logic             sel_req;
  mem_req_t         cur;

  mem_rr_pick u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (last),
    .grant (grant),
    .valid (gvalid)
  );

  // In IDLE look at the requester about to be granted, otherwise at the owner.
  assign sel_idx = (state == IDLE) ? grant : owner;
  assign sel_req = sel_idx ? m1_req : m0_req;

  always_comb begin
    if (sel_idx) begin
      cur.addr   = {{(64-AW){1'b0}}, m1_addr};
      cur.wr     = m1_wr;
      cur.atomic = m1_atomic;
      cur.wdata  = m1_wdata;
      cur.wtag   = m1_wtag;
    end else begin
      cur.addr   = {{(64-AW){1'b0}}, m0_addr};
      cur.wr     = m0_wr;
      cur.atomic = m0_atomic;
      cur.wdata  = m0_wdata;
      cur.wtag   = m0_wtag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock     <= 1'b0;
      cnt      <= '0;
      m0_ack   <= 1'b0;
      m0_rdata <= '0;
      m0_rtag  <= '0;
      m1_ack   <= 1'b0;
      m1_rdata <= '0;
      m1_rtag  <= '0;
      o_ad     <= '0;
      o_tag    <= '0;
      o_astb   <= 1'b0;
      o_atomic <= 1'b0;
      o_rd     <= 1'b0;
      o_wr     <= 1'b0;
      busy     <= 1'b0;
      owner    <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle unless a state re-asserts them.
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      o_astb <= 1'b0;
      o_rd   <= 1'b0;
      o_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (gvalid) begin
            state    <= ADDR;
            owner    <= grant;
            last     <= grant;
            busy     <= 1'b1;
            o_astb   <= 1'b1;
            o_ad     <= cur.addr;
            // A write flagged atomic is an ordinary write: no lock.
            o_atomic <= cur.atomic & ~cur.wr;
            lock     <= cur.atomic & ~cur.wr;
          end
        end
        ADDR: begin
          if (cur.wr) begin
            state <= WR;
            o_wr  <= 1'b1;
            o_ad  <= cur.wdata;
            o_tag <= cur.wtag;
          end else begin
            state <= RD;
            o_rd  <= 1'b1;
          end
        end
        RD: begin
          state <= RWAIT;
          cnt   <= LAT_W'(1);
        end
        RWAIT: begin
          if (cnt == LAT) begin
            state <= DONE;
            if (owner) begin
              m1_rdata <= i_data;
              m1_rtag  <= i_tag;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= i_data;
              m0_rtag  <= i_tag;
              m0_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          // Ends both plain writes and the write half of a locked sequence.
          state    <= DONE;
          o_atomic <= 1'b0;
          lock     <= 1'b0;
          m0_ack   <= ~owner;
          m1_ack   <= owner;
        end
        DONE: begin
          if (lock) begin
            state <= HOLD;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            o_atomic <= 1'b0;
          end
        end
        HOLD: begin
          // Only the lock owner is serviced; the address phase is not repeated.
          if (sel_req) begin
            if (cur.wr) begin
              state <= WR;
              o_wr  <= 1'b1;
              o_ad  <= cur.wdata;
              o_tag <= cur.wtag;
            end else begin
              state    <= DONE;
              lock     <= 1'b0;
              o_atomic <= 1'b0;
              m0_ack   <= ~owner;
              m1_ack   <= owner;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a memory model and scoreboard

module tb_mem_arbiter;

  localparam int AW     = 20;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req    [2];
  logic          wr     [2];
  logic          atomic [2];
  logic [AW-1:0] addr   [2];
  logic [63:0]   wdata  [2];
  logic [7:0]    wtag   [2];
  logic          ack    [2];
  logic [63:0]   rdata  [2];
  logic [7:0]    rtag   [2];
  logic [63:0]   o_ad, i_data;
  logic [7:0]    o_tag, i_tag;
  logic          o_astb, o_atomic, o_rd, o_wr, busy, owner;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_wr(wr[0]), .m0_atomic(atomic[0]),
    .m0_wdata(wdata[0]), .m0_wtag(wtag[0]),
    .m0_ack(ack[0]), .m0_rdata(rdata[0]), .m0_rtag(rtag[0]),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_wr(wr[1]), .m1_atomic(atomic[1]),
    .m1_wdata(wdata[1]), .m1_wtag(wtag[1]),
    .m1_ack(ack[1]), .m1_rdata(rdata[1]), .m1_rtag(rtag[1]),
    .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb), .o_atomic(o_atomic),
    .o_rd(o_rd), .o_wr(o_wr), .i_data(i_data), .i_tag(i_tag),
    .busy(busy), .owner(owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory environment (stands in for tmemory) ----------------
  logic [71:0] mem [int];
  int cyc = 0;
  int rd_due = -1;
  int rd_addr = 0;
  int maddr = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == rd_due) {i_data, i_tag} = mem.exists(rd_addr) ? mem[rd_addr] : 72'h0;
    else begin
      i_data = {$urandom, $urandom};
      i_tag  = 8'($urandom);
    end
  end

  initial forever begin
    @(negedge clk);
    check("one_strobe", 72'((o_astb & o_rd) | (o_astb & o_wr) | (o_rd & o_wr)), 72'h0);
    if (o_astb) maddr = int'(o_ad[AW-1:0]);
    if (o_wr) mem[maddr] = {o_ad, o_tag};
    if (o_rd) begin
      rd_due  = cyc + RD_LAT;
      rd_addr = maddr;
    end
  end

  // ---------------- reference model ----------------
  logic [71:0] ref_mem [int];
  logic        held      [2];
  int          hold_addr [2];
  logic [71:0] last_rd   [2];
  int          ack_cyc   [2];
  int          model_last = 1;
  logic        t_astb [8], t_rd [8], t_wr [8], t_at [8];
  logic [63:0] t_ad   [8];
  logic [7:0]  t_tag  [8];

  function automatic logic [71:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 72'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      held[i]    = 1'b0;
      last_rd[i] = 72'h0;
    end
    model_last = 1;
  endtask

  // One request from requester n; lat = ack cycle relative to the cycle req is raised.
  task automatic do_txn(input int n, input logic w, input logic at, input logic [AW-1:0] a,
                        input logic [63:0] wd, input logic [7:0] wt,
                        output int lat, output int na, output int nr, output int nw);
    lat = -1; na = 0; nr = 0; nw = 0;
    @(posedge clk); #1;
    req[n] = 1'b1; wr[n] = w; atomic[n] = at; addr[n] = a; wdata[n] = wd; wtag[n] = wt;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      na += int'(o_astb); nr += int'(o_rd); nw += int'(o_wr);
      if (k < 8) begin
        t_astb[k] = o_astb; t_rd[k] = o_rd; t_wr[k] = o_wr; t_at[k] = o_atomic;
        t_ad[k] = o_ad; t_tag[k] = o_tag;
      end
      if (ack[n]) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("ack_timeout", 72'h0, 72'h1);
    else begin
      ack_cyc[n] = cyc;
      check("other_ack", 72'(ack[1-n]), 72'h0);
      check("owner", 72'(owner), 72'(n));
      check("lock_excl", 72'(held[1-n]), 72'h0);
      model_last = n;
      if (held[n]) begin
        if (w) ref_mem[hold_addr[n]] = {wd, wt};
        else check("release_rdata", {rdata[n], rtag[n]}, last_rd[n]);
        held[n] = 1'b0;
      end else if (w) begin
        ref_mem[int'(a)] = {wd, wt};
      end else begin
        last_rd[n] = ref_rd(int'(a));
        check("rdata", {rdata[n], rtag[n]}, last_rd[n]);
        if (at) begin
          held[n]      = 1'b1;
          hold_addr[n] = int'(a);
        end
      end
    end
    @(posedge clk); #1;
    req[n] = 1'b0; addr[n] = AW'($urandom); wdata[n] = {$urandom, $urandom};
    wtag[n] = 8'($urandom); wr[n] = 1'($urandom); atomic[n] = 1'($urandom);
  endtask

  task automatic run_rand(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int op, l, x, y, z;
      logic [AW-1:0] a;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op = $urandom_range(0, 3);
      a  = AW'($urandom_range(0, 7));
      case (op)
        0: do_txn(n, 1'b1, 1'b0, a, {$urandom, $urandom}, 8'($urandom), l, x, y, z);
        1: do_txn(n, 1'b0, 1'b0, a, {$urandom, $urandom}, 8'($urandom), l, x, y, z);
        2: begin
          do_txn(n, 1'b0, 1'b1, a, {$urandom, $urandom}, 8'($urandom), l, x, y, z);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_txn(n, 1'($urandom), 1'b0, AW'($urandom), {$urandom, $urandom}, 8'($urandom),
                 l, x, y, z);
        end
        default: do_txn(n, 1'b1, 1'b1, a, {$urandom, $urandom}, 8'($urandom), l, x, y, z);
      endcase
    end
  endtask

  int lat, na, nr, nw;
  int l0, a0, r0, w0, l1, a1, r1, w1;
  int win;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; atomic[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; wtag[i] = '0;
    end
    i_data = '0; i_tag = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_ad", 72'(o_ad), 72'h0);
    check("rst_o_tag", 72'(o_tag), 72'h0);
    check("rst_strobes", {69'h0, o_astb, o_rd, o_wr}, 72'h0);
    check("rst_o_atomic", 72'(o_atomic), 72'h0);
    check("rst_busy", 72'(busy), 72'h0);
    check("rst_owner", 72'(owner), 72'h0);
    check("rst_acks", {70'h0, ack[0], ack[1]}, 72'h0);
    check("rst_rd0", {rdata[0], rtag[0]}, 72'h0);
    check("rst_rd1", {rdata[1], rtag[1]}, 72'h0);
    @(posedge clk); #1 reset = 1'b0;

    // m0 write: address phase c1, data phase c2, ack c3
    do_txn(0, 1'b1, 1'b0, 20'h00123, 64'h0123_4567_89AB_CDEF, 8'h35, lat, na, nr, nw);
    check("wr_lat", 72'(lat), 72'd3);
    check("wr_c1_astb", 72'(t_astb[1]), 72'h1);
    check("wr_c1_ad", 72'(t_ad[1]), 72'h123);
    check("wr_c2_wr", 72'(t_wr[2]), 72'h1);
    check("wr_c2_astb", 72'(t_astb[2]), 72'h0);
    check("wr_c2_ad", 72'(t_ad[2]), 72'h0123_4567_89AB_CDEF);
    check("wr_c2_tag", 72'(t_tag[2]), 72'h35);
    check("mem_holds", mem.exists(32'h123) ? mem[32'h123] : 72'h0, {64'h0123_4567_89AB_CDEF, 8'h35});

    // m1 read of the same word
    do_txn(1, 1'b0, 1'b0, 20'h00123, 64'h0, 8'h0, lat, na, nr, nw);
    check("rd_lat", 72'(lat), 72'(3 + RD_LAT));
    check("rd_c2_rd", 72'(t_rd[2]), 72'h1);
    check("rd_count", 72'(nr), 72'h1);
    check("rd_data", 72'(rdata[1]), 72'h0123_4567_89AB_CDEF);
    check("rd_tag", 72'(rtag[1]), 72'h35);

    // Atomic read by m0 with m1 waiting; locked write; then m1 served
    fork
      begin
        do_txn(0, 1'b0, 1'b1, 20'h00010, 64'h0, 8'h0, l0, a0, r0, w0);
        check("at_rd_lat", 72'(l0), 72'(3 + RD_LAT));
        repeat (3) begin
          @(negedge clk);
          check("hold_atomic", 72'(o_atomic), 72'h1);
          check("hold_busy", 72'(busy), 72'h1);
          check("hold_owner", 72'(owner), 72'h0);
        end
        do_txn(0, 1'b1, 1'b0, 20'h00010, 64'h5, 8'h0, l0, a0, r0, w0);
        check("lk_wr_lat", 72'(l0), 72'd2);
        check("lk_wr_no_astb", 72'(a0), 72'h0);
        check("lk_wr_count", 72'(w0), 72'h1);
        check("lk_wr_atomic", 72'(t_at[1]), 72'h1);
      end
      begin
        @(posedge clk);
        do_txn(1, 1'b0, 1'b0, 20'h00010, 64'h0, 8'h0, l1, a1, r1, w1);
      end
    join
    check("m1_after_lock", 72'(ack_cyc[1] > ack_cyc[0]), 72'h1);
    check("m1_sees_locked_wr", 72'(rdata[1]), 72'h5);

    // Reset during RWAIT
    @(posedge clk); #1;
    req[1] = 1'b1; wr[1] = 1'b0; atomic[1] = 1'b0; addr[1] = 20'h00123;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req[1] = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_mid_ack", {70'h0, ack[0], ack[1]}, 72'h0);
    check("rst_mid_strobes", {68'h0, o_astb, o_rd, o_wr, o_atomic}, 72'h0);
    check("rst_mid_busy", 72'(busy), 72'h0);
    check("rst_mid_rdata", {rdata[1], rtag[1]}, 72'h0);
    do_txn(1, 1'b0, 1'b0, 20'h00123, 64'h0, 8'h0, lat, na, nr, nw);
    check("post_rst_lat", 72'(lat), 72'(3 + RD_LAT));

    // Simultaneous requests: the one not granted last goes first, one IDLE gap
    repeat (2) begin
      win = 1 - model_last;
      fork
        do_txn(0, 1'b1, 1'b0, AW'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom),
               l0, a0, r0, w0);
        do_txn(1, 1'b1, 1'b0, AW'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom),
               l1, a1, r1, w1);
      join
      check("arb_order", 72'(ack_cyc[win] < ack_cyc[1-win]), 72'h1);
      check("arb_gap", 72'(ack_cyc[1-win] - ack_cyc[win]), 72'd4);
    end

    // Random concurrent traffic against the scoreboard
    fork
      run_rand(0, 40);
      run_rand(1, 40);
    join

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
